// File: rtl/semi_auto_nav_if.sv
// Bundle of the semi-auto navigator's command, detector and drive signals.
// The master side sources mode/detectors/commands; the slave side is the navigator.
interface semi_auto_nav_if;
  logic       enable;
  logic [3:0] detectors;    // {front, back, left, right}, 1 = obstacle
  logic       cmd_forward;
  logic       cmd_left;
  logic       cmd_right;

  logic       move_forward;
  logic       move_backward;
  logic       turn_left;
  logic       turn_right;
  logic [2:0] nav_state;
  logic       fork_seen;
  logic [7:0] fork_count;

  modport master (
    output enable, detectors, cmd_forward, cmd_left, cmd_right,
    input  move_forward, move_backward, turn_left, turn_right,
           nav_state, fork_seen, fork_count
  );

  modport slave (
    input  enable, detectors, cmd_forward, cmd_left, cmd_right,
    output move_forward, move_backward, turn_left, turn_right,
           nav_state, fork_seen, fork_count
  );
endinterface

// File: rtl/semi_auto_nav.sv
// Semi-automatic corridor navigator: drives forward, stops at stable forks, turns on command.
// Define AUTO_NAV_EN to let the detector snapshot at a fork pick the route (incl. U-turn).
module semi_auto_nav #(
  parameter int TURN_CYCLES   = 50000000,
  parameter int SETTLE_CYCLES = 25000000,
  parameter int FORK_STABLE   = 100000
) (
  input logic            sys_clk,
  input logic            rst,
  semi_auto_nav_if.slave nav
);

  localparam int TIMER_MAX = (2 * TURN_CYCLES > SETTLE_CYCLES) ? 2 * TURN_CYCLES : SETTLE_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int SW        = $clog2(FORK_STABLE + 1);

  localparam logic [TW-1:0] TURN_LEN   = TW'(TURN_CYCLES);
  localparam logic [TW-1:0] UTURN_LEN  = TW'(2 * TURN_CYCLES);
  localparam logic [TW-1:0] SETTLE_LEN = TW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] STABLE_LEN = SW'(FORK_STABLE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_WAIT   = 3'd2,
    S_TURN   = 3'd3,
    S_SETTLE = 3'd4
  } nav_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } turn_dir_e;

  nav_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  turn_dir_e     dir_q, dir_d;
  logic          uturn_q, uturn_d;
  logic          fork_seen_q, fork_seen_d;
  logic [7:0]    fork_count_q, fork_count_d;

`ifdef AUTO_NAV_EN
  logic [2:0]    snap_q, snap_d;          // {front_open, left_open, right_open} at WAIT entry
  logic          snap_valid_q, snap_valid_d;
`endif

  logic          front_open, left_open, right_open;
  logic          fork_cond;
  logic          auto_taken;
  logic [TW-1:0] timer_inc;
  logic [TW-1:0] turn_len;
  logic [SW-1:0] stable_inc;
  logic          back_unused;

  assign front_open  = ~nav.detectors[3];
  assign left_open   = ~nav.detectors[1];
  assign right_open  = ~nav.detectors[0];
  assign back_unused = nav.detectors[2];
  assign fork_cond   = left_open | right_open | ~front_open;

  assign timer_inc  = timer_q + TW'(1);
  assign stable_inc = stable_q + SW'(1);
  assign turn_len   = uturn_q ? UTURN_LEN : TURN_LEN;

  always_comb begin
    // NOTE: every *_d gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    stable_d     = stable_q;
    dir_d        = dir_q;
    uturn_d      = uturn_q;
    fork_seen_d  = 1'b0;
    fork_count_d = fork_count_q;
    auto_taken   = 1'b0;
`ifdef AUTO_NAV_EN
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
`endif

    if (!nav.enable) begin
      // Leaving semi-auto mode abandons any manoeuvre in progress.
      state_d  = S_IDLE;
      timer_d  = '0;
      stable_d = '0;
      dir_d    = DIR_LEFT;
      uturn_d  = 1'b0;
`ifdef AUTO_NAV_EN
      snap_valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_MOVE;
          timer_d  = '0;
          stable_d = '0;
        end

        S_MOVE: begin
          if (!fork_cond) begin
            stable_d = '0;
          end else if (stable_inc == STABLE_LEN) begin
            state_d     = S_WAIT;
            stable_d    = '0;
            fork_seen_d = 1'b1;
            if (fork_count_q != 8'hFF) fork_count_d = fork_count_q + 8'd1;
`ifdef AUTO_NAV_EN
            snap_d       = {front_open, left_open, right_open};
            snap_valid_d = 1'b1;
`endif
          end else begin
            stable_d = stable_inc;
          end
        end

        S_WAIT: begin
`ifdef AUTO_NAV_EN
          if (snap_valid_q) begin
            snap_valid_d = 1'b0;
            auto_taken   = 1'b1;
            unique case (snap_q)
              3'b100: begin
                state_d = S_SETTLE;
                timer_d = '0;
              end
              3'b010: begin
                state_d = S_TURN;
                timer_d = '0;
                dir_d   = DIR_LEFT;
                uturn_d = 1'b0;
              end
              3'b001: begin
                state_d = S_TURN;
                timer_d = '0;
                dir_d   = DIR_RIGHT;
                uturn_d = 1'b0;
              end
              3'b000: begin
                state_d = S_TURN;
                timer_d = '0;
                dir_d   = DIR_LEFT;
                uturn_d = 1'b1;
              end
              default: auto_taken = 1'b0;  // several ways open: the user decides
            endcase
          end
`endif
          if (!auto_taken) begin
            if (nav.cmd_forward) begin
              state_d = S_SETTLE;
              timer_d = '0;
            end else if (nav.cmd_left) begin
              state_d = S_TURN;
              timer_d = '0;
              dir_d   = DIR_LEFT;
              uturn_d = 1'b0;
            end else if (nav.cmd_right) begin
              state_d = S_TURN;
              timer_d = '0;
              dir_d   = DIR_RIGHT;
              uturn_d = 1'b0;
            end
          end
        end

        S_TURN: begin
          if (timer_inc == turn_len) begin
            state_d = S_SETTLE;
            timer_d = '0;
            uturn_d = 1'b0;
          end else begin
            timer_d = timer_inc;
          end
        end

        S_SETTLE: begin
          if (timer_inc == SETTLE_LEN) begin
            state_d  = S_MOVE;
            timer_d  = '0;
            stable_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      stable_q     <= '0;
      dir_q        <= DIR_LEFT;
      uturn_q      <= 1'b0;
      fork_seen_q  <= 1'b0;
      fork_count_q <= '0;
`ifdef AUTO_NAV_EN
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stable_q     <= stable_d;
      dir_q        <= dir_d;
      uturn_q      <= uturn_d;
      fork_seen_q  <= fork_seen_d;
      fork_count_q <= fork_count_d;
`ifdef AUTO_NAV_EN
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
`endif
    end
  end

  // Drive outputs depend on registered state only, so they never glitch with detector noise.
  assign nav.move_forward  = (state_q == S_MOVE) || (state_q == S_SETTLE);
  assign nav.move_backward = 1'b0;
  assign nav.turn_left     = (state_q == S_TURN) && (dir_q == DIR_LEFT);
  assign nav.turn_right    = (state_q == S_TURN) && (dir_q == DIR_RIGHT);
  assign nav.nav_state     = state_q;
  assign nav.fork_seen     = fork_seen_q;
  assign nav.fork_count    = fork_count_q;

endmodule

// File: tb/tb_semi_auto_nav.sv
// Self-checking bench for semi_auto_nav: directed scenarios plus random traffic,
// compared every cycle against a countdown-based behavioural model.
module tb_semi_auto_nav;

  localparam int TC = 8;
  localparam int SC = 4;
  localparam int FS = 3;

  localparam int P_IDLE   = 0;
  localparam int P_MOVE   = 1;
  localparam int P_WAIT   = 2;
  localparam int P_TURN   = 3;
  localparam int P_SETTLE = 4;

`ifdef AUTO_NAV_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst;

  always #5 sys_clk = ~sys_clk;

  semi_auto_nav_if nav ();

  semi_auto_nav #(
    .TURN_CYCLES  (TC),
    .SETTLE_CYCLES(SC),
    .FORK_STABLE  (FS)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .nav    (nav)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase, cycles remaining in the timed phases, fork streak.
  int       m_phase;
  int       m_remaining;
  int       m_streak;
  bit       m_right;
  int       m_forks;
  bit       m_pulse;
  bit       m_pending;
  bit [3:0] m_snap;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic start_turn(input bit right, input int cycles);
    m_phase     = P_TURN;
    m_right     = right;
    m_remaining = cycles;
  endtask

  task automatic start_settle();
    m_phase     = P_SETTLE;
    m_remaining = SC;
  endtask

  task automatic model_step();
    bit fork_now;
    bit decided;
    bit f_open, l_open, r_open;
    int n_open;
    bit pulse_next;
    pulse_next = 1'b0;
    if (!rst) begin
      m_phase = P_IDLE; m_remaining = 0; m_streak = 0; m_right = 1'b0;
      m_forks = 0; m_pending = 1'b0;
    end else if (!nav.enable) begin
      m_phase = P_IDLE; m_remaining = 0; m_streak = 0; m_right = 1'b0;
      m_pending = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_phase  = P_MOVE;
          m_streak = 0;
        end
        P_MOVE: begin
          fork_now = !nav.detectors[1] || !nav.detectors[0] || nav.detectors[3];
          m_streak = fork_now ? m_streak + 1 : 0;
          if (m_streak == FS) begin
            m_phase    = P_WAIT;
            m_streak   = 0;
            pulse_next = 1'b1;
            if (m_forks < 255) m_forks++;
            m_snap     = nav.detectors;
            m_pending  = AUTO;
          end
        end
        P_WAIT: begin
          decided = 1'b0;
          if (m_pending) begin
            m_pending = 1'b0;
            f_open = !m_snap[3];
            l_open = !m_snap[1];
            r_open = !m_snap[0];
            n_open = int'(f_open) + int'(l_open) + int'(r_open);
            if (n_open == 0) begin
              start_turn(1'b0, 2 * TC);
              decided = 1'b1;
            end else if (n_open == 1) begin
              decided = 1'b1;
              if (f_open) start_settle();
              else if (l_open) start_turn(1'b0, TC);
              else start_turn(1'b1, TC);
            end
          end
          if (!decided) begin
            if (nav.cmd_forward) start_settle();
            else if (nav.cmd_left) start_turn(1'b0, TC);
            else if (nav.cmd_right) start_turn(1'b1, TC);
          end
        end
        P_TURN: begin
          m_remaining--;
          if (m_remaining == 0) start_settle();
        end
        P_SETTLE: begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_phase  = P_MOVE;
            m_streak = 0;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    m_pulse = pulse_next;
  endtask

  task automatic compare_all();
    check("nav_state",     32'(nav.nav_state),     32'(m_phase));
    check("move_forward",  32'(nav.move_forward),  32'(m_phase == P_MOVE || m_phase == P_SETTLE));
    check("move_backward", 32'(nav.move_backward), 32'(0));
    check("turn_left",     32'(nav.turn_left),     32'(m_phase == P_TURN && !m_right));
    check("turn_right",    32'(nav.turn_right),    32'(m_phase == P_TURN && m_right));
    check("fork_seen",     32'(nav.fork_seen),     32'(m_pulse));
    check("fork_count",    32'(nav.fork_count),    32'(m_forks));
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a fork pattern long enough to be accepted, then return to a plain corridor.
  task automatic take_fork(input logic [3:0] pattern);
    nav.detectors = pattern;
    steps(FS);
    nav.detectors = 4'b0011;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int tl_cycles;
    int fwd_cycles;

    rst             = 1'b0;
    nav.enable      = 1'b1;
    nav.detectors   = 4'b0011;
    nav.cmd_forward = 1'b0;
    nav.cmd_left    = 1'b0;
    nav.cmd_right   = 1'b0;

    // Reset held two cycles, then first transition to MOVE.
    steps(2);
    check("reset_state", 32'(nav.nav_state), 32'(P_IDLE));
    rst = 1'b1;
    step();
    check("first_move", 32'(nav.nav_state), 32'(P_MOVE));
    steps(3);
    check("corridor_no_fork", 32'(nav.fork_count), 32'(0));

    // Stable left-open fork: exactly one pulse, count 1.
    pulses = 0;
    nav.detectors = 4'b0001;
    for (int i = 0; i < FS; i++) begin
      step();
      pulses += int'(nav.fork_seen);
    end
    nav.detectors = 4'b0011;
    check("fork_enters_wait", 32'(nav.nav_state), 32'(P_WAIT));
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(nav.fork_seen);
    end
    check("fork_pulse_once", 32'(pulses), 32'(1));
    check("fork_count_one", 32'(nav.fork_count), 32'(1));

    // Both turn commands: left wins, held TC cycles, then SETTLE for SC cycles.
    nav.cmd_left  = 1'b1;
    nav.cmd_right = 1'b1;
    step();
    nav.cmd_left  = 1'b0;
    nav.cmd_right = 1'b0;
    tl_cycles = 0;
    for (int i = 0; i < TC; i++) begin
      tl_cycles += int'(nav.turn_left);
      step();
    end
    check("turn_left_cycles", 32'(tl_cycles), 32'(TC));
    fwd_cycles = 0;
    for (int i = 0; i < SC; i++) begin
      fwd_cycles += int'(nav.move_forward && nav.nav_state == 3'(P_SETTLE));
      step();
    end
    check("settle_cycles", 32'(fwd_cycles), 32'(SC));
    check("settle_to_move", 32'(nav.nav_state), 32'(P_MOVE));

    // A fork glitch shorter than the stability window is ignored.
    nav.detectors = 4'b0001;
    steps(FS - 1);
    nav.detectors = 4'b0011;
    steps(4);
    check("glitch_stays_move", 32'(nav.nav_state), 32'(P_MOVE));

    // Reset in the middle of a right turn.
    take_fork(4'b0001);
    nav.cmd_right = 1'b1;
    step();
    nav.cmd_right = 1'b0;
    steps(4);
    rst = 1'b0;
    step();
    check("midturn_rst_drives", 32'({nav.move_forward, nav.move_backward, nav.turn_left, nav.turn_right}), 32'(0));
    check("midturn_rst_count", 32'(nav.fork_count), 32'(0));
    rst = 1'b1;
    step();

    // Dropping enable during SETTLE returns to IDLE immediately.
    take_fork(4'b0001);
    nav.cmd_forward = 1'b1;
    step();
    nav.cmd_forward = 1'b0;
    steps(2);
    nav.enable = 1'b0;
    step();
    check("settle_disable_idle", 32'(nav.nav_state), 32'(P_IDLE));
    nav.enable = 1'b1;
    step();

    // Dead end: U-turn with auto navigation, otherwise WAIT holds.
    take_fork(4'b1011);
    tl_cycles = 0;
    for (int i = 0; i < 2 * TC + 8; i++) begin
      step();
      tl_cycles += int'(nav.turn_left);
    end
    check("dead_end_turn_left", 32'(tl_cycles), AUTO ? 32'(2 * TC) : 32'(0));
    nav.cmd_forward = 1'b1;
    step();
    nav.cmd_forward = 1'b0;
    steps(SC + 2);

    // Saturation of the fork counter.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      nav.detectors = 4'b0001;
      for (int i = 0; i < FS; i++) begin
        step();
        pulses += int'(nav.fork_seen);
      end
      nav.detectors   = 4'b0011;
      nav.cmd_forward = 1'b1;
      step();
      pulses += int'(nav.fork_seen);
      nav.cmd_forward = 1'b0;
      steps(SC);
    end
    check("sat_pulses", 32'(pulses), 32'(256));
    check("sat_count", 32'(nav.fork_count), 32'(255));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 199) != 0);
      nav.enable      = ($urandom_range(0, 79) != 0);
      nav.detectors   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0011;
      nav.cmd_forward = ($urandom_range(0, 3) == 0);
      nav.cmd_left    = ($urandom_range(0, 3) == 0);
      nav.cmd_right   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
